// File: rtl/farm_pkg.sv
// Shared types and defaults for the task farm: slot states, data width and worker count.
// Used by the scheduler top, its per-worker slot FSM and the worker array.
package farm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_t;

    localparam int FARM_N  = 8;
    localparam int FARM_NW = 4;

    // Pointer width that still works for a single worker.
    function automatic int ptrWidth(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/farm_slot.sv
// One worker slot of the farm scheduler: tracks whether a task is outstanding on its worker
// and flags when that worker's result may be collected.
import farm_pkg::*;

module farm_slot (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        done_i,
    input  logic        ack_i,
    output slot_state_t state_o,
    output logic        collectable_o
);

    slot_state_t state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        collectable_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = BUSY;
            end
            BUSY: begin
                collectable_o = done_i;
                if (ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/farm_sched.sv
// Round-robin dispatch / in-order collect scheduler for the worker farm.
// Optional FARM_SCHED_STATS_EN adds saturating accepted-task and input-stall counters.
import farm_pkg::*;

module farm_sched #(
    parameter int N  = FARM_N,
    parameter int NW = FARM_NW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [N-1:0]    in_data_i,
    output logic [NW-1:0]   w_start_o,
    output logic [N-1:0]    w_arg_o,
    input  logic [NW-1:0]   w_done_i,
    input  logic [NW*N-1:0] w_res_i,
    output logic [NW-1:0]   w_ack_o,
`ifdef FARM_SCHED_STATS_EN
    output logic [31:0]     stat_tasks_o,
    output logic [31:0]     stat_stall_o,
`endif
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [N-1:0]    out_data_o
);

    localparam int PW = ptrWidth(NW);

    logic [PW-1:0] dPtr_q, dPtr_d;
    logic [PW-1:0] cPtr_q, cPtr_d;
    logic [NW-1:0] wStart_q, wStart_d;
    logic [NW-1:0] wAck_q, wAck_d;
    logic [N-1:0]  wArg_q, wArg_d;
    logic          outValid_q, outValid_d;
    logic [N-1:0]  outData_q, outData_d;

    logic [NW-1:0] dHot, cHot, slotIdle, slotCollectable;
    logic          inReady, accept, collect;
    logic [N-1:0]  colData;
    slot_state_t   slotState [NW];

    for (genvar g = 0; g < NW; g++) begin : g_slot
        assign dHot[g]     = (dPtr_q == PW'(g));
        assign cHot[g]     = (cPtr_q == PW'(g));
        assign slotIdle[g] = (slotState[g] == IDLE);

        farm_slot u_slot (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .start_i       (accept && dHot[g]),
            .done_i        (w_done_i[g]),
            .ack_i         (collect && cHot[g]),
            .state_o       (slotState[g]),
            .collectable_o (slotCollectable[g])
        );
    end

    // Only the slot under each pointer can accept or be collected, which keeps results in order.
    assign inReady = |(dHot & slotIdle);
    assign accept  = in_valid_i && inReady;
    assign collect = (|(cHot & slotCollectable)) && (!outValid_q || out_ready_i);

    always_comb begin
        colData = '0;
        for (int i = 0; i < NW; i++) begin
            if (cHot[i]) colData = w_res_i[i*N +: N];
        end
    end

    always_comb begin
        dPtr_d     = dPtr_q;
        cPtr_d     = cPtr_q;
        wStart_d   = '0;
        wAck_d     = '0;
        wArg_d     = wArg_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;

        if (accept) begin
            dPtr_d   = (dPtr_q == PW'(NW-1)) ? '0 : dPtr_q + PW'(1);
            wStart_d = dHot;
            wArg_d   = in_data_i;
        end

        // A collect refills the output register even while it drains, keeping one result per cycle.
        if (collect) begin
            cPtr_d     = (cPtr_q == PW'(NW-1)) ? '0 : cPtr_q + PW'(1);
            wAck_d     = cHot;
            outValid_d = 1'b1;
            outData_d  = colData;
        end else if (outValid_q && out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dPtr_q     <= '0;
            cPtr_q     <= '0;
            wStart_q   <= '0;
            wAck_q     <= '0;
            wArg_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            dPtr_q     <= dPtr_d;
            cPtr_q     <= cPtr_d;
            wStart_q   <= wStart_d;
            wAck_q     <= wAck_d;
            wArg_q     <= wArg_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

`ifdef FARM_SCHED_STATS_EN
    logic [31:0] statTasks_q, statStall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            statTasks_q <= '0;
            statStall_q <= '0;
        end else begin
            if (accept && (statTasks_q != '1)) statTasks_q <= statTasks_q + 32'd1;
            if (in_valid_i && !inReady && (statStall_q != '1)) statStall_q <= statStall_q + 32'd1;
        end
    end

    assign stat_tasks_o = statTasks_q;
    assign stat_stall_o = statStall_q;
`endif

    assign in_ready_o  = inReady;
    assign w_start_o   = wStart_q;
    assign w_ack_o     = wAck_q;
    assign w_arg_o     = wArg_q;
    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;

endmodule

// File: tb/tb_farm_sched.sv
// Directed testbench for farm_sched with a behavioural 4-worker array computing f(x) = 3x+1.
// Builds with or without FARM_SCHED_STATS_EN; counter checks are only present when it is defined.
module tb_farm_sched;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inData;
    logic [3:0]  wStart;
    logic [7:0]  wArg;
    logic [3:0]  wDone;
    logic [31:0] wRes;
    logic [3:0]  wAck;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outData;
`ifdef FARM_SCHED_STATS_EN
    logic [31:0] statTasks;
    logic [31:0] statStall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] gotQ[$];
    int         dispQ[$];

    int         wLat[4];
    int         wCnt[4];
    logic [7:0] wArgHeld[4];

    always #5 clk = ~clk;

    farm_sched dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_data_i   (inData),
        .w_start_o   (wStart),
        .w_arg_o     (wArg),
        .w_done_i    (wDone),
        .w_res_i     (wRes),
        .w_ack_o     (wAck),
`ifdef FARM_SCHED_STATS_EN
        .stat_tasks_o(statTasks),
        .stat_stall_o(statStall),
`endif
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_data_o  (outData)
    );

    function automatic logic [7:0] f(input logic [7:0] x);
        return x * 8'd3 + 8'd1;
    endfunction

    // Worker model: latches its operand on w_start, raises w_done after wLat cycles, drops it on w_ack.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wDone <= '0;
            for (int i = 0; i < 4; i++) begin
                wCnt[i]     <= 0;
                wArgHeld[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wAck[i]) wDone[i] <= 1'b0;
                if (wStart[i]) begin
                    wArgHeld[i] <= wArg;
                    wCnt[i]     <= wLat[i];
                end else if (wCnt[i] != 0) begin
                    wCnt[i] <= wCnt[i] - 1;
                    if (wCnt[i] == 1) wDone[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        wRes = '0;
        for (int i = 0; i < 4; i++) wRes[i*8 +: 8] = f(wArgHeld[i]);
    end

    // Records delivered results and dispatch targets mid-cycle.
    always @(negedge clk) begin
        if (rstN) begin
            if (outValid && outReady) gotQ.push_back(outData);
            for (int i = 0; i < 4; i++) begin
                if (wStart[i]) dispQ.push_back(i);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        repeat (2) tick();
        gotQ.delete();
        dispQ.delete();
        rstN = 1'b1;
        tick();
    endtask

    // Presents one operand and waits (bounded) until it is accepted.
    task automatic applyStimulus(input logic [7:0] v, output bit ok);
        ok      = 1'b0;
        inValid = 1'b1;
        inData  = v;
        for (int k = 0; k < 40; k++) begin
            if (inReady) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        inValid = 1'b0;
    endtask

    task automatic waitResults(input int n);
        for (int k = 0; k < 60; k++) begin
            if (gotQ.size() >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rstN    = 1'b0;
        inValid = 1'b0;
        #2;
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady); end
        checks++; if (wStart !== 4'b0) begin failures++; $display("[TB] FAIL reset_w_start got=%b exp=0000", wStart); end
        checks++; if (wArg !== 8'd0) begin failures++; $display("[TB] FAIL reset_w_arg got=%0d exp=0", wArg); end
        checks++; if (wAck !== 4'b0) begin failures++; $display("[TB] FAIL reset_w_ack got=%b exp=0000", wAck); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid); end
        checks++; if (outData !== 8'd0) begin failures++; $display("[TB] FAIL reset_out_data got=%0d exp=0", outData); end
        applyReset();
    endtask

    task automatic test_single();
        bit ok;
        bit seen;
        int ackCount;
        applyReset();
        wLat = '{3, 3, 3, 3};
        applyStimulus(8'd5, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL single_accept got=%b exp=1", ok); end
        checks++; if (wStart !== 4'b0001) begin failures++; $display("[TB] FAIL single_w_start got=%b exp=0001", wStart); end
        checks++; if (wArg !== 8'd5) begin failures++; $display("[TB] FAIL single_w_arg got=%0d exp=5", wArg); end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (wDone[0]) begin seen = 1'b1; break; end
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL single_w_done got=%b exp=1", seen); end
        tick();
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL single_out_valid got=%b exp=1", outValid); end
        checks++; if (outData !== f(8'd5)) begin failures++; $display("[TB] FAIL single_out_data got=%0d exp=16", outData); end
        checks++; if (wAck !== 4'b0001) begin failures++; $display("[TB] FAIL single_w_ack got=%b exp=0001", wAck); end
        ackCount = 1;
        repeat (4) begin
            tick();
            if (wAck[0]) ackCount++;
        end
        checks++; if (ackCount !== 1) begin failures++; $display("[TB] FAIL single_ack_count got=%0d exp=1", ackCount); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL single_out_drained got=%b exp=0", outValid); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit allOk;
        logic [7:0] ops[5];
        int expW[5];
        ops  = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8};
        expW = '{0, 1, 2, 3, 0};
        applyReset();
        wLat  = '{2, 2, 2, 2};
        allOk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ops[i], ok);
            allOk &= ok;
        end
        checks++; if (allOk !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept got=%b exp=1", allOk); end
        waitResults(5);
        checks++; if (gotQ.size() !== 5) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=5", gotQ.size()); end
        if (gotQ.size() == 5 && dispQ.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (dispQ[i] !== expW[i]) begin failures++; $display("[TB] FAIL b2b_worker[%0d] got=%0d exp=%0d", i, dispQ[i], expW[i]); end
                checks++; if (gotQ[i] !== f(ops[i])) begin failures++; $display("[TB] FAIL b2b_result[%0d] got=%0d exp=%0d", i, gotQ[i], f(ops[i])); end
            end
        end
    endtask

    task automatic test_out_of_order();
        bit ok;
        bit allOk;
        bit seen;
        applyReset();
        wLat  = '{6, 1, 1, 1};
        allOk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(i), ok);
            allOk &= ok;
        end
        checks++; if (allOk !== 1'b1) begin failures++; $display("[TB] FAIL ooo_accept got=%b exp=1", allOk); end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (wDone === 4'b1110) begin seen = 1'b1; break; end
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL ooo_done_pattern got=%b exp=1110", wDone); end
        checks++; if ({outValid, wAck} !== 5'b0) begin failures++; $display("[TB] FAIL ooo_held got=%b exp=00000", {outValid, wAck}); end
        waitResults(4);
        checks++; if (gotQ.size() !== 4) begin failures++; $display("[TB] FAIL ooo_count got=%0d exp=4", gotQ.size()); end
        if (gotQ.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (gotQ[i] !== f(8'(i))) begin failures++; $display("[TB] FAIL ooo_result[%0d] got=%0d exp=%0d", i, gotQ[i], f(8'(i))); end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit allOk;
        bit seen;
        applyReset();
        wLat  = '{5, 5, 5, 5};
        allOk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(10 + i), ok);
            allOk &= ok;
        end
        checks++; if (allOk !== 1'b1) begin failures++; $display("[TB] FAIL stall_accept got=%b exp=1", allOk); end
        checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL stall_full_ready got=%b exp=0", inReady); end
        inValid = 1'b1;
        inData  = 8'd14;
        seen    = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (wAck[0]) begin seen = 1'b1; break; end
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL stall_ack0 got=%b exp=1", seen); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL stall_ready_after_ack got=%b exp=1", inReady); end
        tick();
        inValid = 1'b0;
        checks++; if (wStart !== 4'b0001) begin failures++; $display("[TB] FAIL stall_fifth_w_start got=%b exp=0001", wStart); end
        checks++; if (wArg !== 8'd14) begin failures++; $display("[TB] FAIL stall_fifth_w_arg got=%0d exp=14", wArg); end
`ifdef FARM_SCHED_STATS_EN
        checks++; if (statStall !== 32'd4) begin failures++; $display("[TB] FAIL stat_stall got=%0d exp=4", statStall); end
        checks++; if (statTasks !== 32'd5) begin failures++; $display("[TB] FAIL stat_tasks got=%0d exp=5", statTasks); end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        bit allOk;
        bit seen;
        applyReset();
        wLat     = '{1, 1, 1, 1};
        outReady = 1'b0;
        allOk    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'(20 + i), ok);
            allOk &= ok;
        end
        checks++; if (allOk !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept got=%b exp=1", allOk); end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (outValid) begin seen = 1'b1; break; end
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_valid got=%b exp=1", seen); end
        checks++; if (outData !== f(8'd20)) begin failures++; $display("[TB] FAIL bp_first_data got=%0d exp=%0d", outData, f(8'd20)); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({outValid, outData, wAck} !== {1'b1, f(8'd20), 4'b0000}) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d] got valid=%b data=%0d ack=%b exp valid=1 data=%0d ack=0000", k, outValid, outData, wAck, f(8'd20));
            end
        end
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({outValid, outData} !== {1'b1, f(8'(20 + i))}) begin
                failures++;
                $display("[TB] FAIL bp_drain[%0d] got valid=%b data=%0d exp valid=1 data=%0d", i, outValid, outData, f(8'(20 + i)));
            end
            tick();
        end
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_empty got=%b exp=0", outValid); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit allOk;
        applyReset();
        wLat     = '{1, 10, 10, 10};
        outReady = 1'b0;
        allOk    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(40 + i), ok);
            allOk &= ok;
        end
        checks++; if (allOk !== 1'b1) begin failures++; $display("[TB] FAIL rmid_accept got=%b exp=1", allOk); end
        checks++; if ({outValid, inReady} !== 2'b10) begin failures++; $display("[TB] FAIL rmid_pre got=%b exp=10", {outValid, inReady}); end
        rstN = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_out_valid got=%b exp=0", outValid); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL rmid_in_ready got=%b exp=1", inReady); end
        checks++; if ({wStart, wAck} !== 8'b0) begin failures++; $display("[TB] FAIL rmid_pulses got=%b exp=00000000", {wStart, wAck}); end
        tick();
        rstN     = 1'b1;
        outReady = 1'b1;
        tick();
        applyStimulus(8'd33, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rmid_post_accept got=%b exp=1", ok); end
        checks++; if (wStart !== 4'b0001) begin failures++; $display("[TB] FAIL rmid_post_w_start got=%b exp=0001", wStart); end
        checks++; if (wArg !== 8'd33) begin failures++; $display("[TB] FAIL rmid_post_w_arg got=%0d exp=33", wArg); end
    endtask

    initial begin
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        wLat     = '{1, 1, 1, 1};
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_order();
        test_stall();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
